// File: rtl/line_state_array.sv
// Per-(set,way) valid/dirty state store with a live dirty-line count and a flush walker
// that offers every valid+dirty line to the cache controller for write-back.
module line_state_array #(
    parameter int ASSOC          = 8,
    parameter int INDEX_SIZE     = 7,
    parameter int INVAL_ON_FLUSH = 0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [INDEX_SIZE-1:0]                        index,
    input  logic [$clog2(ASSOC)-1:0]                     way,
    input  logic [2:0]                                   op,
    output logic                                         valid_o,
    output logic                                         dirty_o,
    input  logic                                         flush_req,
    output logic                                         flush_busy,
    output logic                                         wb_valid,
    output logic [INDEX_SIZE-1:0]                        wb_index,
    output logic [$clog2(ASSOC)-1:0]                     wb_way,
    input  logic                                         wb_ready,
    output logic                                         flush_done,
    output logic [$clog2((2**INDEX_SIZE)*ASSOC+1)-1:0]   dirty_count
);
    localparam int WAY_W   = $clog2(ASSOC);
    localparam int SETS    = 2 ** INDEX_SIZE;
    localparam int ENTRIES = SETS * ASSOC;
    localparam int PTR_W   = INDEX_SIZE + WAY_W;
    localparam int CNT_W   = $clog2(ENTRIES + 1);
    localparam bit INVAL   = (INVAL_ON_FLUSH != 0);

    typedef enum logic [1:0] {IDLE, SCAN, OFFER, DONE} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [ENTRIES-1:0] v_q, v_d;
    logic [ENTRIES-1:0] d_q, d_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               upd_en;
    logic [PTR_W-1:0]   upd_idx;
    logic               upd_v;
    logic               upd_d;
    logic               ptr_last;

    assign ptr_last = (ptr_q == {PTR_W{1'b1}});

    // At most one entry is written per cycle: either by a controller op (IDLE only)
    // or by the walker. The single write also drives the dirty-count delta.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        upd_en  = 1'b0;
        upd_idx = {index, way};
        upd_v   = v_q[{index, way}];
        upd_d   = d_q[{index, way}];

        case (state_q)
            IDLE: begin
                case (op)
                    3'd1, 3'd3: begin
                        upd_en = 1'b1;
                        upd_v  = 1'b1;
                        upd_d  = 1'b1;
                    end
                    3'd2: begin
                        upd_en = 1'b1;
                        upd_v  = 1'b1;
                        upd_d  = 1'b0;
                    end
                    3'd4: begin
                        upd_en = 1'b1;
                        upd_d  = 1'b0;
                    end
                    3'd5: begin
                        upd_en = 1'b1;
                        upd_v  = 1'b0;
                        upd_d  = 1'b0;
                    end
                    default: upd_en = 1'b0;
                endcase
                if (flush_req) begin
                    ptr_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                upd_idx = ptr_q;
                upd_v   = v_q[ptr_q];
                upd_d   = d_q[ptr_q];
                if (v_q[ptr_q] && d_q[ptr_q]) begin
                    state_d = OFFER;
                end else begin
                    if (INVAL) begin
                        upd_en = 1'b1;
                        upd_v  = 1'b0;
                    end
                    if (ptr_last) state_d = DONE;
                    else          ptr_d   = ptr_q + PTR_W'(1);
                end
            end
            OFFER: begin
                upd_idx = ptr_q;
                upd_v   = v_q[ptr_q];
                upd_d   = d_q[ptr_q];
                if (wb_ready) begin
                    upd_en = 1'b1;
                    upd_d  = 1'b0;
                    if (INVAL) upd_v = 1'b0;
                    if (ptr_last) begin
                        state_d = DONE;
                    end else begin
                        ptr_d   = ptr_q + PTR_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        v_d     = v_q;
        d_d     = d_q;
        count_d = count_q;
        if (upd_en) begin
            v_d[upd_idx] = upd_v;
            d_d[upd_idx] = upd_d;
            if (upd_d && !d_q[upd_idx])      count_d = count_q + CNT_W'(1);
            else if (!upd_d && d_q[upd_idx]) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            v_q     <= '0;
            d_q     <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

    assign valid_o     = v_q[{index, way}];
    assign dirty_o     = d_q[{index, way}];
    assign flush_busy  = (state_q != IDLE);
    assign wb_valid    = (state_q == OFFER);
    assign wb_index    = wb_valid ? ptr_q[PTR_W-1:WAY_W] : '0;
    assign wb_way      = wb_valid ? ptr_q[WAY_W-1:0] : '0;
    assign flush_done  = (state_q == DONE);
    assign dirty_count = count_q;
endmodule

// File: tb/tb_line_state_array.sv
// Directed self-checking bench for line_state_array: two instances cover the
// default walker and the invalidate-on-flush variant.
module tb_line_state_array;
    logic        clk;
    logic        rst;

    logic [6:0]  index;
    logic [2:0]  way;
    logic [2:0]  op;
    logic        valid_o, dirty_o;
    logic        flush_req, flush_busy, wb_valid, wb_ready, flush_done;
    logic [6:0]  wb_index;
    logic [2:0]  wb_way;
    logic [10:0] dirty_count;

    logic [6:0]  i_index;
    logic [2:0]  i_way;
    logic [2:0]  i_op;
    logic        i_valid_o, i_dirty_o;
    logic        i_flush_req, i_flush_busy, i_wb_valid, i_wb_ready, i_flush_done;
    logic [6:0]  i_wb_index;
    logic [2:0]  i_wb_way;
    logic [10:0] i_dirty_count;

    int          checks;
    int          failures;
    int          cyc;
    int          start_cyc;
    int          n;
    bit          saw_offer;

    line_state_array #(.ASSOC(8), .INDEX_SIZE(7), .INVAL_ON_FLUSH(0)) dut (
        .clk(clk), .rst(rst), .index(index), .way(way), .op(op),
        .valid_o(valid_o), .dirty_o(dirty_o), .flush_req(flush_req),
        .flush_busy(flush_busy), .wb_valid(wb_valid), .wb_index(wb_index),
        .wb_way(wb_way), .wb_ready(wb_ready), .flush_done(flush_done),
        .dirty_count(dirty_count)
    );

    line_state_array #(.ASSOC(8), .INDEX_SIZE(7), .INVAL_ON_FLUSH(1)) dut_inv (
        .clk(clk), .rst(rst), .index(i_index), .way(i_way), .op(i_op),
        .valid_o(i_valid_o), .dirty_o(i_dirty_o), .flush_req(i_flush_req),
        .flush_busy(i_flush_busy), .wb_valid(i_wb_valid), .wb_index(i_wb_index),
        .wb_way(i_wb_way), .wb_ready(i_wb_ready), .flush_done(i_flush_done),
        .dirty_count(i_dirty_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [6:0] s, input logic [2:0] w);
        op    = o;
        index = s;
        way   = w;
        tick();
        op    = 3'd0;
    endtask

    // Waits on dut: sel 0 = wb_valid, 1 = flush_done; sel 2 = dut_inv flush_done
    task automatic waitFor(input int sel, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (sel == 0 && wb_valid) break;
            if (sel == 1 && flush_done) break;
            if (sel == 2 && i_flush_done) break;
            if (i_wb_valid) saw_offer = 1'b1;
            tick();
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; saw_offer = 1'b0;
        rst = 1'b1; index = '0; way = '0; op = '0; flush_req = 1'b0; wb_ready = 1'b0;
        i_index = '0; i_way = '0; i_op = '0; i_flush_req = 1'b0; i_wb_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // 1: reset state, all entries clear
        checkOutput("rst_count", dirty_count, 0);
        checkOutput("rst_busy", flush_busy, 0);
        checkOutput("rst_wb_valid", wb_valid, 0);
        checkOutput("rst_wb_index", wb_index, 0);
        checkOutput("rst_wb_way", wb_way, 0);
        checkOutput("rst_flush_done", flush_done, 0);
        for (int s = 0; s < 128; s++) begin
            for (int w = 0; w < 8; w++) begin
                index = 7'(s);
                way   = 3'(w);
                #1;
                checkOutput($sformatf("rst_vd_%0d_%0d", s, w), {valid_o, dirty_o}, 0);
            end
        end

        // 2: clean fill, write hit, write-back done on (3,2)
        applyStimulus(3'd2, 7'd3, 3'd2);
        checkOutput("fill_clean_v", valid_o, 1);
        checkOutput("fill_clean_d", dirty_o, 0);
        checkOutput("fill_clean_cnt", dirty_count, 0);
        applyStimulus(3'd1, 7'd3, 3'd2);
        checkOutput("wr_hit_d", dirty_o, 1);
        checkOutput("wr_hit_cnt", dirty_count, 1);
        applyStimulus(3'd4, 7'd3, 3'd2);
        checkOutput("wb_done_d", dirty_o, 0);
        checkOutput("wb_done_v", valid_o, 1);
        checkOutput("wb_done_cnt", dirty_count, 0);

        // 3: flush with wb_ready held high
        applyStimulus(3'd3, 7'd0, 3'd0);
        applyStimulus(3'd3, 7'd5, 3'd7);
        applyStimulus(3'd3, 7'd127, 3'd7);
        checkOutput("t3_cnt_pre", dirty_count, 3);
        wb_ready = 1'b1;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        start_cyc = cyc;
        checkOutput("t3_busy", flush_busy, 1);
        waitFor(0, 2000);
        checkOutput("t3_offer0_v", wb_valid, 1);
        checkOutput("t3_offer0_idx", {wb_index, wb_way}, {7'd0, 3'd0});
        tick();
        waitFor(0, 2000);
        checkOutput("t3_offer1_v", wb_valid, 1);
        checkOutput("t3_offer1_idx", {wb_index, wb_way}, {7'd5, 3'd7});
        checkOutput("t3_offer1_cnt", dirty_count, 2);
        tick();
        waitFor(0, 2000);
        checkOutput("t3_offer2_v", wb_valid, 1);
        checkOutput("t3_offer2_idx", {wb_index, wb_way}, {7'd127, 3'd7});
        tick();
        waitFor(1, 2000);
        checkOutput("t3_done", flush_done, 1);
        checkOutput("t3_latency", cyc - start_cyc, 1027);
        checkOutput("t3_cnt_post", dirty_count, 0);
        tick();
        checkOutput("t3_done_pulse", flush_done, 0);
        checkOutput("t3_idle", flush_busy, 0);
        index = 7'd3; way = 3'd2; #1;
        checkOutput("t3_clean_kept_v", valid_o, 1);
        wb_ready = 1'b0;

        // 4: stall at (5,7); ops and flush_req during busy ignored
        applyStimulus(3'd3, 7'd0, 3'd0);
        applyStimulus(3'd3, 7'd5, 3'd7);
        applyStimulus(3'd3, 7'd127, 3'd7);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        waitFor(0, 2000);
        checkOutput("t4_offer0_idx", {wb_index, wb_way}, {7'd0, 3'd0});
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        waitFor(0, 2000);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("t4_hold_v_%0d", k), wb_valid, 1);
            checkOutput($sformatf("t4_hold_idx_%0d", k), {wb_index, wb_way}, {7'd5, 3'd7});
            if (k == 3) begin
                op = 3'd3; index = 7'd10; way = 3'd0; flush_req = 1'b1;
            end
            tick();
            op = 3'd0; flush_req = 1'b0;
        end
        checkOutput("t4_hold_cnt", dirty_count, 2);
        wb_ready = 1'b1;
        tick();
        waitFor(0, 2000);
        checkOutput("t4_offer2_idx", {wb_index, wb_way}, {7'd127, 3'd7});
        tick();
        waitFor(1, 2000);
        checkOutput("t4_done", flush_done, 1);
        tick();
        checkOutput("t4_idle", flush_busy, 0);
        tick();
        checkOutput("t4_no_restart", flush_busy, 0);
        index = 7'd10; way = 3'd0; #1;
        checkOutput("t4_op_ignored_v", valid_o, 0);
        checkOutput("t4_cnt_post", dirty_count, 0);
        wb_ready = 1'b0;

        // 5: invalidate-on-flush variant clears a clean line without offering it
        i_op = 3'd2; i_index = 7'd9; i_way = 3'd1;
        tick();
        i_op = 3'd0;
        checkOutput("t5_fill_v", i_valid_o, 1);
        i_flush_req = 1'b1;
        tick();
        i_flush_req = 1'b0;
        start_cyc = cyc;
        saw_offer = 1'b0;
        waitFor(2, 2000);
        checkOutput("t5_done", i_flush_done, 1);
        checkOutput("t5_latency", cyc - start_cyc, 1024);
        checkOutput("t5_no_offer", saw_offer, 0);
        tick();
        checkOutput("t5_inval_v", i_valid_o, 0);

        // 6: reset while offering aborts the walk
        applyStimulus(3'd3, 7'd2, 3'd3);
        checkOutput("t6_cnt_pre", dirty_count, 1);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        waitFor(0, 2000);
        checkOutput("t6_offer_idx", {wb_index, wb_way}, {7'd2, 3'd3});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_wb_valid", wb_valid, 0);
        checkOutput("t6_busy", flush_busy, 0);
        checkOutput("t6_cnt", dirty_count, 0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("t6_no_done_%0d", k), flush_done, 0);
            tick();
        end
        index = 7'd3; way = 3'd2; #1;
        checkOutput("t6_v_cleared", valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
